// File: rtl/prng_bit_dealer_pkg.sv
// Shared definitions for the PRNG bit dealer: FSM states, word geometry and
// the xoroshiro64* output multiplier.
package prng_bit_dealer_pkg;

    typedef enum logic [1:0] {
        ST_SEED  = 2'd0,
        ST_PRIME = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SERVE = 2'd3
    } dealer_state_e;

    // Width of one generator word and of the bit counter that tracks it.
    localparam int WORD_W  = 32;
    localparam int COUNT_W = $clog2(WORD_W + 1);

    // xoroshiro64* scrambler multiplier.
    localparam logic [31:0] XOROSHIRO64S_MUL = 32'h9E37_79BB;

endpackage

// File: rtl/prng_bit_dealer_xoroshiro64s.sv
// xoroshiro64* generator core. No reset: state is defined only by a seed load.
// o_result is registered, so it trails the state by one enabled cycle.
module prng_bit_dealer_xoroshiro64s
    import prng_bit_dealer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_cg,
    input  logic        i_seedValid,
    input  logic [31:0] i_seedS0,
    input  logic [31:0] i_seedS1,
    output logic [31:0] o_result
);

    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s1_mix;

    assign s1_mix = s1 ^ s0;

    // Publish the scrambled s0 and either load a seed or step the state.
    always_ff @(posedge i_clk) begin
        if (i_cg) begin
            o_result <= s0 * XOROSHIRO64S_MUL;
            if (i_seedValid) begin
                s0 <= i_seedS0;
                s1 <= i_seedS1;
            end else begin
                s0 <= {s0[5:0], s0[31:6]} ^ s1_mix ^ (s1_mix << 9);
                s1 <= {s1_mix[18:0], s1_mix[31:19]};
            end
        end
    end

endmodule

// File: rtl/prng_bit_dealer.sv
// Deals 32-bit xoroshiro64* words out as WIDTH-bit chunks, LSB first, over a
// valid/ready handshake. A fresh word is pulled in the same cycle the last
// chunk of the previous one is accepted, so there is no bubble between words.
module prng_bit_dealer
    import prng_bit_dealer_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter logic [31:0] SEED_S0 = 32'h1,
    parameter logic [31:0] SEED_S1 = 32'h0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_reseed,
    input  logic [31:0]      i_reseedS0,
    input  logic [31:0]      i_reseedS1,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    dealer_state_e        state;
    dealer_state_e        state_next;
    logic [31:0]          seed_s0;
    logic [31:0]          seed_s1;
    logic [WORD_W-1:0]    buffer;
    logic [COUNT_W-1:0]   bit_count;
    logic                 prng_cg;
    logic                 prng_seed_valid;
    logic [31:0]          prng_result;
    logic                 handshake;
    logic                 word_done;

    assign o_valid   = (state == ST_SERVE);
    assign o_data    = buffer[WIDTH-1:0];
    assign handshake = o_valid & i_ready;
    assign word_done = (bit_count == COUNT_W'(WIDTH));

    prng_bit_dealer_xoroshiro64s u_prng (
        .i_clk       (i_clk),
        .i_cg        (prng_cg),
        .i_seedValid (prng_seed_valid),
        .i_seedS0    (seed_s0),
        .i_seedS1    (seed_s1),
        .o_result    (prng_result)
    );

    // Sequence seed -> prime -> load -> serve; the generator only steps when
    // it is being seeded, flushed, or its current word is taken.
    always_comb begin
        state_next      = state;
        prng_cg         = 1'b0;
        prng_seed_valid = 1'b0;
        case (state)
            ST_SEED: begin
                prng_cg         = 1'b1;
                prng_seed_valid = 1'b1;
                state_next      = ST_PRIME;
            end
            ST_PRIME: begin
                prng_cg    = 1'b1;
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                prng_cg    = 1'b1;
                state_next = ST_SERVE;
            end
            ST_SERVE: begin
                prng_cg = handshake & word_done;
            end
            default: state_next = ST_SEED;
        endcase
        if (i_reseed) begin
            state_next = ST_SEED;
        end
    end

    // State register; reset always lands in SEED.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_SEED;
        end else begin
            state <= state_next;
        end
    end

    // Seed latch plus chunk buffer: shift out WIDTH bits per accepted chunk,
    // refill from the generator when the last chunk of a word goes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seed_s0   <= SEED_S0;
            seed_s1   <= SEED_S1;
            buffer    <= '0;
            bit_count <= '0;
        end else if (i_reseed) begin
            seed_s0   <= i_reseedS0;
            seed_s1   <= i_reseedS1;
            buffer    <= '0;
            bit_count <= '0;
        end else if (state == ST_LOAD) begin
            buffer    <= prng_result;
            bit_count <= COUNT_W'(WORD_W);
        end else if (handshake) begin
            if (word_done) begin
                buffer    <= prng_result;
                bit_count <= COUNT_W'(WORD_W);
            end else begin
                buffer    <= buffer >> WIDTH;
                bit_count <= bit_count - COUNT_W'(WIDTH);
            end
        end
    end

endmodule

// File: doc/prng_bit_dealer.md
PRNG_BIT_DEALER -- requirements
Module: prngBitDealer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: output chunk width; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter SEED_S0, default 32'h1: s0 seed loaded by reset.
REQ-003 SHALL have parameter SEED_S1, default 32'h0: s1 seed loaded by reset.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset; synchronous, active-high.
REQ-006 i_reseed  input  1  one-cycle request to reseed from i_reseedS0/i_reseedS1.
REQ-007 i_reseedS0  input  32  s0 seed, sampled when i_reseed=1.
REQ-008 i_reseedS1  input  32  s1 seed, sampled when i_reseed=1.
REQ-009 o_valid  output  1  o_data holds an unconsumed random chunk.
REQ-010 i_ready  input  1  consumer accepts o_data when o_valid=1.
REQ-011 o_data  output  WIDTH  random chunk.

Function
REQ-012 SHALL instantiate one prngXoroshiro64s and drive its i_clk, i_cg, i_seedValid, i_seedS0 and i_seedS1 inputs; i_cg SHALL be 1 only in the cycles stated below.
REQ-013 FSM states SHALL be SEED, PRIME, LOAD and SERVE.
REQ-014 SEED: i_seedValid=1, i_cg=1, seeds = latched seed pair, o_valid=0; next state PRIME.
REQ-015 PRIME: i_cg=1, i_seedValid=0, o_valid=0; next state LOAD. This flushes the stale result so that o_result equals seedS0*0x9E3779BB.
REQ-016 LOAD: 32-bit buffer <= PRNG o_result, bit count <= 32, i_cg=1, o_valid=0; next state SERVE.
REQ-017 SERVE: o_valid=1; o_data = buffer[WIDTH-1:0], so chunks leave LSB first.
REQ-018 Handshake in SERVE (o_valid & i_ready) with count>WIDTH: buffer shifts right by WIDTH, zero-filled; count -= WIDTH.
REQ-019 Handshake with count==WIDTH: buffer <= o_result, count <= 32 and i_cg=1 in the same cycle; no bubble, and o_valid stays 1.
REQ-020 o_valid=1 with i_ready=0: o_data and buffer SHALL hold stable, and i_cg=0.
REQ-021 Throughput SHALL be one chunk per cycle under continuous i_ready=1; every PRNG word SHALL be consumed exactly once, with no skipped or repeated bits.
REQ-022 i_reseed=1 in any state: latch the seed pair and go to SEED next cycle, discarding buffer contents. A handshake in that same cycle SHALL count as completed.
REQ-023 After reset or reseed, first o_valid=1 SHALL occur 3 cycles later (SEED, PRIME, LOAD).
REQ-024 The bit count SHALL be $clog2(33) bits wide and never exceed 32; in SERVE it SHALL never be 0.

Reset
REQ-025 i_rst=1 SHALL force state SEED and latch SEED_S0/SEED_S1 as the seed pair.
REQ-026 i_rst=1 SHALL also clear buffer and count to 0, giving o_valid=0 and o_data=0.
REQ-027 i_rst SHALL take priority over i_reseed.
REQ-028 Reset mid-SERVE SHALL discard pending data without a completed handshake.
REQ-029 The PRNG instance has no reset; its state SHALL be defined solely by the SEED cycle.

Structure
REQ-030 FSM state enum and the 0x9E3779BB golden constant (for the bench model) SHALL live in the shared package.
REQ-031 Sole sub-module SHALL be prngXoroshiro64s; the dealer SHALL be one module otherwise.

Verification
REQ-032 Reset release, SEED_S0=1, SEED_S1=0, WIDTH=8, i_ready=1 -> o_valid rises cycle 3. Chunks SHALL be BB,79,37,9E,BB,EF,2A,F9 (words 0x9E3779BB, 0xF92AEFBB).
REQ-033 Same setup, i_ready toggled pseudo-randomly -> identical chunk sequence, and o_data stable while stalled.
REQ-034 Reseed to (1,0) mid-word after 2 chunks -> o_valid low 3 cycles, then restart at BB; the handshake in the reseed cycle is counted.
REQ-035 WIDTH=32 -> one word per cycle, 0x9E3779BB then 0xF92AEFBB; WIDTH=1 -> 32 single bits LSB first, 1,1,0,1,1,1,0,1,...
REQ-036 i_rst and i_reseed asserted together, reseed seeds differing -> sequence SHALL start from SEED_S0/SEED_S1.
REQ-037 The scoreboard's C-model next() over 10^5 chunks with random i_ready SHALL show zero mismatches, and count SHALL never be 0 in SERVE.
